// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC sequencing, IF/ID register, branch redirect
// Handles memory wait states, decode freezes and branches that land on an outstanding request.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        brTaken,
  input  logic [31:0] brOffset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_if_valid;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;

  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;

  assign w_target   = r_if_pc + (brOffset << 2);
  assign w_pc_plus4 = r_pc + 32'd4;

  assign imem_req          = r_req;
  assign imem_addr         = r_addr;
  assign pc                = r_pc;
  assign if_id_instruction = r_if_instr;
  assign if_id_pc          = r_if_pc;
  assign if_id_valid       = r_if_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_if_instr   <= NOP_INSTR;
      r_if_pc      <= 32'd0;
      r_if_valid   <= 1'b0;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= 32'd0;
    end else if (brTaken) begin
      r_pc         <= w_target;
      r_if_instr   <= NOP_INSTR;
      r_if_valid   <= 1'b0;
      r_hold_instr <= NOP_INSTR;
      r_hold_pc    <= 32'd0;
      r_req        <= 1'b1;
      // An unanswered request must still complete at its old address, so r_addr is left alone.
      if ((r_state == FETCH && !imem_ready) || r_state == DROP) begin
        r_state <= DROP;
      end else begin
        r_state <= FETCH;
        r_addr  <= w_target;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end
        FETCH: begin
          if (imem_ready) begin
            if (freeze) begin
              r_hold_instr <= imem_rdata;
              r_hold_pc    <= w_pc_plus4;
              r_state      <= HOLD;
              r_req        <= 1'b0;
            end else begin
              r_if_instr <= imem_rdata;
              r_if_pc    <= w_pc_plus4;
              r_if_valid <= 1'b1;
              r_pc       <= w_pc_plus4;
              r_addr     <= w_pc_plus4;
            end
          end else if (!freeze) begin
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!freeze) begin
            r_if_instr <= r_hold_instr;
            r_if_pc    <= r_hold_pc;
            r_if_valid <= 1'b1;
            r_pc       <= w_pc_plus4;
            r_addr     <= w_pc_plus4;
            r_state    <= FETCH;
            r_req      <= 1'b1;
          end
        end
        DROP: begin
          // Stale data is thrown away; the branch target already sits in r_pc.
          if (imem_ready) begin
            r_state <= FETCH;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        brTaken;
  logic [31:0] brOffset;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic [31:0] w_if_pc;
  logic        w_valid;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_pc;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .brTaken(brTaken), .brOffset(brOffset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(pc), .if_id_instruction(if_id_instruction),
    .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
    .clk(clk), .rst(rst), .freeze(freeze), .brTaken(brTaken), .brOffset(brOffset),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc(w_pc), .if_id_instruction(w_instr),
    .if_id_pc(w_if_pc), .if_id_valid(w_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_pop(input string tag);
    logic [63:0] e;
    check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_instr"}, if_id_instruction, e[63:32]);
      check({tag, "_if_pc"}, if_id_pc, e[31:0]);
      check({tag, "_valid"}, 32'(if_id_valid), 32'd1);
    end
  endtask

  task automatic load_word(input logic [31:0] data);
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    imem_ready = 1'b1;
    imem_rdata = data;
    sb_q.push_back({data, exp_pc + 32'd4});
    tick();
    sb_pop("load");
    exp_pc = exp_pc + 32'd4;
    check("load_pc", pc, exp_pc);
    imem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    freeze     = 1'b0;
    brTaken    = 1'b0;
    brOffset   = 32'd0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_pc = 32'd0;
    sb_q.delete();
  endtask

  initial begin
    rst = 1'b1; freeze = 1'b0; brTaken = 1'b0; brOffset = 32'd0;
    imem_ready = 1'b0; imem_rdata = 32'd0; exp_pc = 32'd0;
    tick();
    tick();
    check("rst_pc", pc, 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instr", if_id_instruction, NOP);
    check("rst_if_pc", if_id_pc, 32'd0);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);

    // IDLE cycle first, request only in the following cycle
    rst = 1'b0;
    tick();
    check("first_req", 32'(imem_req), 32'd1);
    check("wrap_first_addr", w_addr, 32'hFFFF_FFFC);

    load_word(32'hA0);
    check("wrap_if_pc", w_if_pc, 32'd0);
    check("wrap_instr", w_instr, 32'hA0);
    check("wrap_valid", 32'(w_valid), 32'd1);
    check("wrap_second_addr", w_addr, 32'd0);
    check("wrap_pc", w_pc, 32'd0);
    for (int n = 1; n < 4; n++) load_word(32'hA0 + n);

    // wait states at pc=4
    do_reset();
    load_word(32'hB0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bubble_valid", 32'(if_id_valid), 32'd0);
      check("bubble_instr", if_id_instruction, NOP);
      check("bubble_if_pc", if_id_pc, 32'd4);
      check("bubble_addr", imem_addr, 32'd4);
    end
    load_word(32'hB4);

    // freeze while the word at pc=8 returns
    do_reset();
    load_word(32'hC0);
    load_word(32'hC4);
    freeze = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      imem_ready = 1'b0;
      check("hold_req", 32'(imem_req), 32'd0);
      check("hold_instr", if_id_instruction, 32'hC4);
      check("hold_if_pc", if_id_pc, 32'd8);
      check("hold_pc", pc, 32'd8);
    end
    freeze = 1'b0;
    sb_q.push_back({32'h1234, 32'd12});
    tick();
    sb_pop("release");
    exp_pc = 32'd12;
    check("release_pc", pc, exp_pc);
    load_word(32'hCC);

    // branch while a request is outstanding
    do_reset();
    for (int n = 0; n < 4; n++) load_word(32'hD0 + 4 * n);
    brTaken = 1'b1;
    brOffset = 32'hFFFF_FFFE;
    tick();
    brTaken = 1'b0;
    check("drop_pc", pc, 32'd8);
    check("drop_addr", imem_addr, 32'd16);
    check("drop_req", 32'(imem_req), 32'd1);
    check("drop_valid", 32'(if_id_valid), 32'd0);
    check("drop_if_pc", if_id_pc, 32'd16);
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD;
    tick();
    imem_ready = 1'b0;
    check("late_valid", 32'(if_id_valid), 32'd0);
    check("late_instr", if_id_instruction, NOP);
    exp_pc = 32'd8;
    load_word(32'hE8);

    // branch and freeze together
    do_reset();
    for (int n = 0; n < 5; n++) load_word(32'h50 + n);
    brTaken = 1'b1;
    freeze = 1'b1;
    brOffset = 32'd3;
    imem_ready = 1'b1;
    imem_rdata = 32'hBAD;
    tick();
    brTaken = 1'b0;
    freeze = 1'b0;
    imem_ready = 1'b0;
    check("brfz_pc", pc, 32'd32);
    check("brfz_addr", imem_addr, 32'd32);
    check("brfz_instr", if_id_instruction, NOP);
    check("brfz_valid", 32'(if_id_valid), 32'd0);
    exp_pc = 32'd32;
    load_word(32'hF0);

    // reset during DROP, in-flight response ignored
    do_reset();
    load_word(32'h60);
    load_word(32'h64);
    brTaken = 1'b1;
    brOffset = 32'd1;
    tick();
    brTaken = 1'b0;
    check("drop2_addr", imem_addr, 32'd8);
    check("drop2_pc", pc, 32'd12);
    rst = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'hBEEF;
    tick();
    check("mid_rst_pc", pc, 32'd0);
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_instr", if_id_instruction, NOP);
    check("mid_rst_if_pc", if_id_pc, 32'd0);
    check("mid_rst_valid", 32'(if_id_valid), 32'd0);
    rst = 1'b0;
    tick();
    imem_ready = 1'b0;
    check("post_rst_valid", 32'(if_id_valid), 32'd0);
    check("post_rst_instr", if_id_instruction, NOP);
    check("post_rst_addr", imem_addr, 32'd0);
    check("post_rst_pc", pc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, instruction word driven into IF/ID on bubble or flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 freeze  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-006 brTaken  input  1  branch resolved taken in decode this cycle.
REQ-007 brOffset  input  32  sign-extended word offset of the branch in decode.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  byte address of the request.
REQ-010 imem_ready  input  1  memory accepts request and returns data this cycle.
REQ-011 imem_rdata  input  32  instruction word, valid when imem_req && imem_ready.
REQ-012 pc  output  32  current fetch PC.
REQ-013 if_id_instruction  output  32  IF/ID instruction register.
REQ-014 if_id_pc  output  32  IF/ID register holding fetch address + 4.
REQ-015 if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-016 FSM states SHALL be IDLE, FETCH, HOLD and DROP.
REQ-017 IDLE: imem_req=0; next state FETCH unconditionally.
REQ-018 FETCH: imem_req=1, imem_addr=pc; address SHALL stay stable until imem_ready.
REQ-019 FETCH, ready=1, freeze=0, brTaken=0: IF/ID <= {rdata, pc+4, valid=1}; pc <= pc+4; stay FETCH (back-to-back fetch, one instruction per cycle at zero-wait memory).
REQ-020 FETCH, ready=1, freeze=1, brTaken=0: rdata and pc+4 captured into a hold buffer; IF/ID unchanged; pc unchanged; go HOLD.
REQ-021 HOLD: imem_req=0; when freeze=0, IF/ID <= hold buffer with valid=1, pc <= pc+4, go FETCH.
REQ-022 FETCH, ready=0, freeze=0, brTaken=0: IF/ID <= {NOP_INSTR, if_id_pc unchanged, valid=0} (bubble).
REQ-023 freeze=1 with brTaken=0 in any state: IF/ID and pc SHALL hold their values.
REQ-024 Branch target = if_id_pc + (brOffset << 2), modulo 2^32.
REQ-025 brTaken SHALL take priority over freeze and over any data returned in the same cycle.
REQ-026 brTaken: pc <= target; IF/ID <= {NOP_INSTR, valid=0}; hold buffer discarded.
REQ-027 brTaken in FETCH with ready=1 or in HOLD/IDLE: next state FETCH at the target.
REQ-028 brTaken in FETCH with ready=0: go DROP.
REQ-029 DROP: imem_req=1 with the old pre-branch address (kept in a separate register); on ready, discard data; go FETCH at the target.
REQ-030 brTaken in DROP: target updated; stay DROP.
REQ-031 PC arithmetic SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-032 if_id_pc SHALL be updated only on a valid load; bubbles preserve its previous value.

Reset
REQ-033 rst=1 at a clock edge: pc=RESET_PC, state=IDLE, imem_req=0, if_id_instruction=NOP_INSTR, if_id_pc=0, if_id_valid=0, hold buffer cleared.
REQ-034 rst SHALL override all other inputs, including mid-transaction; an in-flight memory response after reset SHALL be ignored.
REQ-035 First imem_req SHALL assert in the second cycle after rst deasserts (IDLE then FETCH).

Verification
REQ-036 Zero-wait stream: ready=1, rdata=32'hA0+n -> if_id_pc 4, 8, 12..., valid=1 every cycle from cycle 3.
REQ-037 Freeze during fetch: freeze=1 for 3 cycles when pc=8 returns 32'h1234 -> IF/ID holds prior word, imem_req=0 in HOLD; after release IF/ID=32'h1234, if_id_pc=12.
REQ-038 Wait states: ready=0 for 2 cycles at pc=4 -> two bubbles (valid=0), imem_addr stays 4, then valid load with if_id_pc=8.
REQ-039 Branch with outstanding request: if_id_pc=16, brOffset=-2, brTaken while ready=0 -> DROP; late data discarded; next request addr 8, IF/ID valid=0.
REQ-040 Branch + freeze same cycle: brTaken=1, freeze=1, brOffset=3, if_id_pc=20 -> pc=32, IF/ID flushed to NOP_INSTR.
REQ-041 Reset mid-wait and PC wrap: rst during DROP -> all outputs at reset values next cycle; RESET_PC=32'hFFFF_FFFC -> second fetch addr 0.
